div_radix2: RTL and testbench

//  Iterative radix-2 restoring divider; the responder side of the EX-stage divide handshake (start_i/ready_o).

---
 rtl/div_radix2.sv | 129 ++++++++++++
 tb/tb_div_radix2.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider answering the EX-stage start/ready handshake.
// One quotient bit per cycle; signed/unsigned, divide-by-zero and annul of an op in flight.
module div_radix2 #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] DIV0_QUOT = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);
    // One extra bit so the counter can reach WIDTH for the exit compare.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [WIDTH-1:0]   rem, rem_nxt;
    logic [WIDTH-1:0]   quot, quot_nxt;
    logic [WIDTH-1:0]   dvsr, dvsr_nxt;
    logic               neg_q, neg_q_nxt;
    logic               neg_r, neg_r_nxt;
    logic [2*WIDTH-1:0] result_nxt;
    logic               ready_nxt;

    logic               a_neg, b_neg;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   trial;

    assign a_neg   = signed_div_i & opdata1_i[WIDTH-1];
    assign b_neg   = signed_div_i & opdata2_i[WIDTH-1];
    assign shifted = {rem, quot[WIDTH-1]};
    // Extra top bit acts as the borrow: set means the trial subtraction went negative.
    assign trial   = {1'b0, shifted} - {2'b00, dvsr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            quot     <= '0;
            dvsr     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rem      <= rem_nxt;
            quot     <= quot_nxt;
            dvsr     <= dvsr_nxt;
            neg_q    <= neg_q_nxt;
            neg_r    <= neg_r_nxt;
            result_o <= result_nxt;
            ready_o  <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rem_nxt    = rem;
        quot_nxt   = quot;
        dvsr_nxt   = dvsr;
        neg_q_nxt  = neg_q;
        neg_r_nxt  = neg_r;
        result_nxt = result_o;
        ready_nxt  = ready_o;
        case (state)
            IDLE: begin
                if (start_i && !annul_i) begin
                    quot_nxt  = a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
                    dvsr_nxt  = b_neg ? (~opdata2_i + 1'b1) : opdata2_i;
                    rem_nxt   = '0;
                    cnt_nxt   = '0;
                    neg_q_nxt = a_neg ^ b_neg;
                    neg_r_nxt = a_neg;
                    state_nxt = (opdata2_i == '0) ? DIVZERO : ON;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_nxt = IDLE;
                end else if (cnt == CW'(WIDTH)) begin
                    result_nxt = {neg_r ? (~rem + 1'b1) : rem,
                                  neg_q ? (~quot + 1'b1) : quot};
                    ready_nxt  = 1'b1;
                    state_nxt  = END;
                end else begin
                    if (!trial[WIDTH+1]) begin
                        rem_nxt  = trial[WIDTH-1:0];
                        quot_nxt = {quot[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_nxt  = shifted[WIDTH-1:0];
                        quot_nxt = {quot[WIDTH-2:0], 1'b0};
                    end
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DIVZERO: begin
                // Two cycles here so the result lands at the same slot as the original design.
                if (annul_i) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    cnt_nxt = CW'(1);
                end else begin
                    result_nxt = {{WIDTH{1'b0}}, DIV0_QUOT};
                    ready_nxt  = 1'b1;
                    state_nxt  = END;
                end
            end
            END: begin
                if (!start_i) begin
                    result_nxt = '0;
                    ready_nxt  = 1'b0;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: directed cases plus a randomized regression
// against an arithmetic reference model.
module tb_div_radix2;
    localparam int          W  = 32;
    localparam logic [31:0] D0 = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst, signed_div_i, start_i, annul_i;
    logic [W-1:0]  opdata1_i, opdata2_i;
    logic [2*W-1:0] result_o;
    logic          ready_o;

    int checks   = 0;
    int failures = 0;

    div_radix2 #(.WIDTH(W), .DIV0_QUOT(D0)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {32'd0, D0};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Presents an op, returns cycles from the accept edge to ready_o (100 = timed out).
    // Inputs are scrambled right after accept; the DUT must ignore them.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] res);
        @(negedge clk);
        signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        @(posedge clk); #1;
        signed_div_i = 1'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
        lat = 0;
        while (!ready_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result_o;
    endtask

    task automatic drop_start();
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            failures++;
            $display("FAIL reset: ready=%b result=%h, want ready=0 result=0", ready_o, result_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_divu_basic();
        int lat; logic [63:0] res;
        issue(1'b0, 32'd100, 32'd7, lat, res);
        checks++;
        if (lat !== 33) begin
            failures++; $display("FAIL divu_latency: got %0d want 33", lat);
        end
        checks++;
        if (res !== {32'd2, 32'd14}) begin
            failures++; $display("FAIL divu_100_7: got %h want %h", res, {32'd2, 32'd14});
        end
        // Result holds while start stays high; annul has no effect in END.
        annul_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        annul_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || result_o !== {32'd2, 32'd14}) begin
            failures++; $display("FAIL end_hold: ready=%b result=%h want 1 %h", ready_o, result_o, {32'd2, 32'd14});
        end
        drop_start();
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            failures++; $display("FAIL end_release: ready=%b result=%h want 0 0", ready_o, result_o);
        end
    endtask

    task automatic test_signed();
        int lat; logic [63:0] res;
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, lat, res);
        checks++;
        if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            failures++; $display("FAIL div_m7_2: got %h want ffffffff_fffffffd", res);
        end
        drop_start();
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, lat, res);
        checks++;
        if (res !== {32'h0000_0001, 32'hFFFF_FFFD}) begin
            failures++; $display("FAIL div_7_m2: got %h want 00000001_fffffffd", res);
        end
        drop_start();
    endtask

    task automatic test_overflow();
        int lat; logic [63:0] res;
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
        checks++;
        if (res !== {32'd0, 32'h8000_0000}) begin
            failures++; $display("FAIL div_overflow: got %h want 00000000_80000000", res);
        end
        drop_start();
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
        checks++;
        if (res !== {32'h8000_0000, 32'd0}) begin
            failures++; $display("FAIL divu_big: got %h want 80000000_00000000", res);
        end
        drop_start();
    endtask

    task automatic test_div0();
        int lat; logic [63:0] res;
        issue(1'b0, 32'd5, 32'd0, lat, res);
        checks++;
        if (lat !== 2) begin
            failures++; $display("FAIL div0_latency: got %0d want 2", lat);
        end
        checks++;
        if (res !== {32'd0, D0}) begin
            failures++; $display("FAIL div0_result: got %h want %h", res, {32'd0, D0});
        end
        drop_start();
    endtask

    task automatic test_annul();
        int lat; logic [63:0] res; bit seen;
        // start with annul in the same cycle is never accepted
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready_o) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++; $display("FAIL annul_idle: ready=1 seen, want stays 0");
        end
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        // annul at T+10 of a running op
        @(negedge clk);
        opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0; start_i = 1'b0;
        seen = ready_o;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready_o) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++; $display("FAIL annul_on: ready=1 seen after annul, want 0");
        end
        issue(1'b0, 32'd9, 32'd3, lat, res);
        checks++;
        if (lat !== 33 || res !== {32'd0, 32'd3}) begin
            failures++; $display("FAIL after_annul: lat=%0d res=%h want 33 %h", lat, res, {32'd0, 32'd3});
        end
        drop_start();
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] res;
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd4; start_i = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            failures++; $display("FAIL reset_on: ready=%b result=%h want 0 0", ready_o, result_o);
        end
        rst = 1'b0; start_i = 1'b0;
        issue(1'b0, 32'd77, 32'd4, lat, res);
        checks++;
        if (lat !== 33 || res !== {32'd1, 32'd19}) begin
            failures++; $display("FAIL after_reset_on: lat=%0d res=%h want 33 %h", lat, res, {32'd1, 32'd19});
        end
        // reset while in END with start still high
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            failures++; $display("FAIL reset_end: ready=%b result=%h want 0 0", ready_o, result_o);
        end
        rst = 1'b0; start_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready_o !== 1'b0) begin
            failures++; $display("FAIL reset_end_idle: ready=%b want 0", ready_o);
        end
    endtask

    task automatic test_back_to_back();
        int lat, want_lat; logic [63:0] res, want;
        logic s; logic [31:0] a, b;
        for (int n = 0; n < 1000; n++) begin
            s = 1'($urandom);
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 16);
                3:       b = 32'd1 << $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            want     = model(s, a, b);
            want_lat = (b == 32'd0) ? 2 : 33;
            issue(s, a, b, lat, res);
            checks++;
            if (res !== want || lat !== want_lat) begin
                failures++;
                $display("FAIL regress[%0d] s=%b %h/%h: res=%h lat=%0d want %h lat=%0d",
                         n, s, a, b, res, lat, want, want_lat);
            end
            drop_start();
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_overflow();
        test_div0();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
